// File: rtl/poly_addsub_seq.sv
// Streams paired coefficients from A/B memories (shared read address) and writes
// a-b or a+b, optionally reduced mod Q, to a result memory at one coefficient per cycle.
`timescale 1ns/1ps
module poly_addsub_seq #(
  parameter int N         = 256,
  parameter int Q         = 8380417,
  parameter int COEF_W    = 32,
  parameter int MAX_POLYS = 8,
  parameter int ADDR_W    = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              op,
  input  logic              reduce,
  input  logic [3:0]        num_polys,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [COEF_W-1:0] a_rdata,
  input  logic [COEF_W-1:0] b_rdata,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [COEF_W-1:0] wr_data
);

  // Handshake: the memories return data exactly one cycle after rd_en with no
  // backpressure; wr_en is a fire-and-forget strobe, so there is no ready path.
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state, state_next;
  logic                op_q, reduce_q, drain_cnt;
  logic [3:0]          polys_q, polys_clamped;
  logic [ADDR_W-1:0]   idx, last_idx;
  logic                start_ok;
  logic                s1_valid;
  logic [ADDR_W-1:0]   s1_addr;
  logic [COEF_W-1:0]   diff, sum, result;

  localparam logic [COEF_W-1:0] QV = COEF_W'(Q);

  assign start_ok      = (state == IDLE) && start && !abort;
  assign polys_clamped = (num_polys > 4'(MAX_POLYS)) ? 4'(MAX_POLYS) : num_polys;
  assign last_idx      = ADDR_W'(32'(polys_q) * 32'(N) - 32'd1);

  assign rd_en   = (state == RUN);
  assign rd_addr = idx;
  assign busy    = (state == RUN) || (state == DRAIN);
  assign done    = (state == DONE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_ok) state_next = (num_polys == 4'd0) ? DONE : RUN;
      RUN:     if (idx == last_idx) state_next = DRAIN;
      DRAIN:   if (drain_cnt) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort && state != IDLE) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      drain_cnt <= 1'b0;
      op_q      <= 1'b0;
      reduce_q  <= 1'b0;
      polys_q   <= 4'd0;
    end else begin
      state <= state_next;
      if (start_ok) begin
        op_q     <= op;
        reduce_q <= reduce;
        polys_q  <= polys_clamped;
      end
      // idx parks at 0 outside RUN so rd_addr idles at zero
      if (state == RUN && state_next == RUN) idx <= idx + ADDR_W'(1);
      else                                   idx <= '0;
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
    end
  end

  always_comb begin
    diff   = a_rdata - b_rdata;
    sum    = a_rdata + b_rdata;
    result = '0;
    if (!op_q) result = (reduce_q && diff[COEF_W-1]) ? diff + QV : diff;
    else       result = (reduce_q && ($signed(sum) >= $signed(QV))) ? sum - QV : sum;
  end

  // Stage 1 tracks the address alongside the arriving read data; stage 2
  // registers the arithmetic result straight off the memory outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      s1_valid <= rd_en && !abort;
      s1_addr  <= idx;
      wr_en    <= s1_valid && !abort;
      if (s1_valid) begin
        wr_addr <= s1_addr;
        wr_data <= result;
      end
    end
  end

endmodule

// File: tb/tb_poly_addsub_seq.sv
// Directed bench for poly_addsub_seq: cycle-exact checks of reads, writes,
// busy/done, clamping, abort, ignored restart and mid-job reset.
`timescale 1ns/1ps
module tb_poly_addsub_seq;

  localparam logic [31:0] QC = 32'd8380417;

  logic        clk, rst_n, start, op, reduce, abort;
  logic [3:0]  num_polys;
  logic        busy, done, rd_en, wr_en;
  logic [10:0] rd_addr, wr_addr;
  logic [31:0] a_rdata, b_rdata, wr_data;

  logic [31:0] a_mem [0:2047];
  logic [31:0] b_mem [0:2047];

  int n_cmp = 0;
  int n_err = 0;

  poly_addsub_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .reduce(reduce),
    .num_polys(num_polys), .abort(abort), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .a_rdata(a_rdata), .b_rdata(b_rdata),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous memory model: one-cycle read latency
  always @(posedge clk) begin
    if (rd_en) begin
      a_rdata <= a_mem[rd_addr];
      b_rdata <= b_mem[rd_addr];
    end
  end

  task automatic chk(input string tag, input int cyc, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // pat 0: a=i b=2i ; 1: a=b=Q-1 ; 2: a=0 b=1 ; 3: a=i b=3
  task automatic fill(input int pat);
    for (int i = 0; i < 2048; i++) begin
      case (pat)
        0:       begin a_mem[i] = 32'(i);  b_mem[i] = 32'(2 * i); end
        1:       begin a_mem[i] = QC - 1;  b_mem[i] = QC - 1;     end
        2:       begin a_mem[i] = 32'd0;   b_mem[i] = 32'd1;      end
        default: begin a_mem[i] = 32'(i);  b_mem[i] = 32'd3;      end
      endcase
    end
  endtask

  // hand-derived results for the op/reduce mode each pattern is paired with
  function automatic logic [31:0] exp_data(input int pat, input int i);
    case (pat)
      0:       return (i == 0) ? 32'd0 : QC - 32'(i);
      1:       return QC - 32'd2;
      2:       return 32'hFFFF_FFFF;
      default: return 32'(i) + 32'd3;
    endcase
  endfunction

  // Cycle 1 is the cycle after the edge that samples start.
  task automatic run_job(input logic op_i, input logic red_i, input logic [3:0] np_i,
                         input int p_exp, input int pat, input int abort_cyc,
                         input int rst_cyc, input int restart_cyc, input int ncyc);
    int np, cut, dc;
    np  = p_exp * 256;
    cut = (abort_cyc > 0) ? abort_cyc : ((rst_cyc > 0) ? rst_cyc : 1 << 30);
    dc  = (np == 0) ? 1 : np + 3;
    fill(pat);
    start = 1'b1; op = op_i; reduce = red_i; num_polys = np_i;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      abort = (cyc == abort_cyc);
      rst_n = (cyc != rst_cyc);
      if (cyc == restart_cyc) begin
        start = 1'b1; op = ~op_i; num_polys = 4'd1;
      end else begin
        start = 1'b0; op = op_i; num_polys = np_i;
      end
      @(negedge clk);
      if (rst_cyc > 0 && cyc > rst_cyc) begin
        chk("rst_rd_en", cyc, 32'(rd_en), 32'd0);
        chk("rst_rd_addr", cyc, 32'(rd_addr), 32'd0);
        chk("rst_wr_en", cyc, 32'(wr_en), 32'd0);
        chk("rst_wr_addr", cyc, 32'(wr_addr), 32'd0);
        chk("rst_wr_data", cyc, wr_data, 32'd0);
        chk("rst_busy", cyc, 32'(busy), 32'd0);
        chk("rst_done", cyc, 32'(done), 32'd0);
      end else begin
        chk("rd_en", cyc, 32'(rd_en), 32'(cyc <= np && cyc <= cut));
        if (cyc <= np && cyc <= cut) chk("rd_addr", cyc, 32'(rd_addr), 32'(cyc - 1));
        chk("wr_en", cyc, 32'(wr_en), 32'(cyc >= 3 && cyc <= np + 2 && cyc <= cut));
        if (cyc >= 3 && cyc <= np + 2 && cyc <= cut) begin
          chk("wr_addr", cyc, 32'(wr_addr), 32'(cyc - 3));
          chk("wr_data", cyc, wr_data, exp_data(pat, cyc - 3));
        end
        chk("busy", cyc, 32'(busy), 32'(np > 0 && cyc <= np + 2 && cyc <= cut));
        chk("done", cyc, 32'(done), 32'(cyc == dc && dc <= cut));
      end
      @(posedge clk); #1;
    end
    abort = 1'b0; rst_n = 1'b1; start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 1'b0; reduce = 1'b0; abort = 1'b0;
    num_polys = 4'd0; a_rdata = '0; b_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 0, 32'(busy), 32'd0);
    chk("reset_done", 0, 32'(done), 32'd0);
    chk("reset_rd_en", 0, 32'(rd_en), 32'd0);
    chk("reset_rd_addr", 0, 32'(rd_addr), 32'd0);
    chk("reset_wr_en", 0, 32'(wr_en), 32'd0);
    chk("reset_wr_addr", 0, 32'(wr_addr), 32'd0);
    chk("reset_wr_data", 0, wr_data, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // P=1 sub reduced: Q-i, done in cycle 259
    run_job(1'b0, 1'b1, 4'd1, 1, 0, 0, 0, 0, 260);
    // P=8 add reduced: Q-2 everywhere, done in cycle 2051
    run_job(1'b1, 1'b1, 4'd8, 8, 1, 0, 0, 0, 2052);
    // P=2 sub raw with an ignored second start at cycle 50
    run_job(1'b0, 1'b0, 4'd2, 2, 2, 0, 0, 50, 516);
    // num_polys=0: done in cycle 1, nothing else
    run_job(1'b0, 1'b0, 4'd0, 0, 0, 0, 0, 0, 3);
    // num_polys=12 clamps to 8, add raw a=i b=3
    run_job(1'b1, 1'b0, 4'd12, 8, 3, 0, 0, 0, 2052);
    // abort in cycle 100, then a full job right after
    run_job(1'b0, 1'b1, 4'd1, 1, 0, 100, 0, 0, 101);
    run_job(1'b0, 1'b1, 4'd1, 1, 0, 0, 0, 0, 260);
    // synchronous reset mid-job, then a full job from IDLE
    run_job(1'b1, 1'b0, 4'd1, 1, 3, 0, 120, 0, 122);
    run_job(1'b0, 1'b1, 4'd1, 1, 0, 0, 0, 0, 260);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
